// File: rtl/pipe_ctrl_pkg.sv
// Shared stage indices and FSM encoding for the pipeline controller.
package pipe_ctrl_pkg;

  localparam int IF_S = 0;
  localparam int ID_S = 1;
  localparam int EX_S = 2;

  typedef enum logic [1:0] {
    StRun    = 2'd0,
    StDrain  = 2'd1,
    StHalted = 2'd2
  } state_e;

endpackage

// File: rtl/pipe_ctrl_hazard_cmp.sv
// Compares one ID source register against the shadow destinations of in-flight writers.
module pipe_ctrl_hazard_cmp
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned NUM_STAGES = 5,
  parameter int unsigned REG_AW     = 3,
  parameter int unsigned FORWARD    = 1
) (
  input  logic [REG_AW-1:0]                  src_addr,
  input  logic                               src_used,
  input  logic [NUM_STAGES-1:0][REG_AW-1:0]  rd_vec,
  input  logic [NUM_STAGES-1:0]              wr_vec,
  input  logic [NUM_STAGES-1:0]              load_vec,
  input  logic [NUM_STAGES-1:0]              valid_vec,
  output logic                               hit
);

  // WB writes and is bypassed in the register file, so the window stops at N-2.
  localparam int LastChk = int'(NUM_STAGES) - 2;

  always_comb begin
    hit = 1'b0;
    if (src_used) begin
      for (int s = EX_S; s <= LastChk; s++) begin
        if (valid_vec[s] && wr_vec[s] && (rd_vec[s] == src_addr)) begin
          if ((FORWARD == 0) || ((s == EX_S) && load_vec[s])) begin
            hit = 1'b1;
          end
        end
      end
    end
  end

  // Front-stage and WB shadow bits never take part in a compare.
  logic unused_bits;
  assign unused_bits = ^{rd_vec, wr_vec, load_vec, valid_vec};

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: stage valid tracking, RAW hazard stalls, redirect flush, halt drain.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned NUM_STAGES = 5,
  parameter int unsigned REG_AW     = 3,
  parameter int unsigned FORWARD    = 1,
  parameter int unsigned STALL_MAX  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_valid,
  input  logic [REG_AW-1:0]     id_rs_addr,
  input  logic                  id_rs_used,
  input  logic [REG_AW-1:0]     id_rt_addr,
  input  logic                  id_rt_used,
  input  logic [REG_AW-1:0]     id_rd_addr,
  input  logic                  id_reg_write,
  input  logic                  id_is_load,
  input  logic                  id_halt,
  input  logic                  ex_redirect,
  input  logic                  mem_stall,
  output logic [NUM_STAGES-1:0] stage_en,
  output logic [NUM_STAGES-1:0] stage_valid,
  output logic                  pc_en,
  output logic                  bubble_ex,
  output logic                  flush_front,
  output logic                  halted,
  output logic                  err
);

  localparam int N = int'(NUM_STAGES);
  localparam int unsigned WdogW = $clog2(STALL_MAX + 1);
  localparam logic [WdogW-1:0] WdogMax = WdogW'(STALL_MAX);

  state_e                       state_q, state_d;
  logic [N-1:0]                 valid_q, valid_d;
  logic [N-1:0][REG_AW-1:0]     rd_q, rd_d;
  logic [N-1:0]                 wr_q, wr_d;
  logic [N-1:0]                 load_q, load_d;
  logic [WdogW-1:0]             wdog_q, wdog_d;
  logic                         err_q, err_d;

  logic haz_rs, haz_rt, hazard;
  logic redirect, redirect_bad;

  pipe_ctrl_hazard_cmp #(
    .NUM_STAGES(NUM_STAGES),
    .REG_AW    (REG_AW),
    .FORWARD   (FORWARD)
  ) u_haz_rs (
    .src_addr (id_rs_addr),
    .src_used (id_rs_used & valid_q[ID_S]),
    .rd_vec   (rd_q),
    .wr_vec   (wr_q),
    .load_vec (load_q),
    .valid_vec(valid_q),
    .hit      (haz_rs)
  );

  pipe_ctrl_hazard_cmp #(
    .NUM_STAGES(NUM_STAGES),
    .REG_AW    (REG_AW),
    .FORWARD   (FORWARD)
  ) u_haz_rt (
    .src_addr (id_rt_addr),
    .src_used (id_rt_used & valid_q[ID_S]),
    .rd_vec   (rd_q),
    .wr_vec   (wr_q),
    .load_vec (load_q),
    .valid_vec(valid_q),
    .hit      (haz_rt)
  );

  // Hazards only matter while the front end is still issuing.
  assign hazard       = (haz_rs | haz_rt) & (state_q == StRun);
  assign redirect     = ex_redirect & valid_q[EX_S] & (state_q != StHalted);
  assign redirect_bad = ex_redirect & (~valid_q[EX_S] | (state_q == StHalted));

  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    rd_d        = rd_q;
    wr_d        = wr_q;
    load_d      = load_q;
    wdog_d      = '0;
    err_d       = err_q;
    stage_en    = '0;
    pc_en       = 1'b0;
    bubble_ex   = 1'b0;
    flush_front = 1'b0;

    if (mem_stall) begin
      wdog_d = (wdog_q == WdogMax) ? wdog_q : wdog_q + 1'b1;
      if (wdog_d == WdogMax) begin
        err_d = 1'b1;
      end
    end else begin
      if (redirect_bad) begin
        err_d = 1'b1;
      end
      if (state_q != StHalted) begin
        // Back end always advances; front-end handling differs per case below.
        stage_en = '1;
        for (int s = EX_S + 1; s < N; s++) begin
          valid_d[s] = valid_q[s-1];
          rd_d[s]    = rd_q[s-1];
          wr_d[s]    = wr_q[s-1];
          load_d[s]  = load_q[s-1];
        end
        valid_d[EX_S] = valid_q[ID_S];
        rd_d[EX_S]    = id_rd_addr;
        wr_d[EX_S]    = id_reg_write;
        load_d[EX_S]  = id_is_load;

        if (redirect) begin
          valid_d[EX_S:IF_S] = '0;
          flush_front        = 1'b1;
          pc_en              = 1'b1;
          state_d            = StRun;
        end else if (hazard) begin
          valid_d[EX_S]      = 1'b0;
          stage_en[ID_S:IF_S] = '0;
          bubble_ex          = 1'b1;
        end else if (state_q == StDrain) begin
          valid_d[EX_S:IF_S]  = '0;
          stage_en[ID_S:IF_S] = '0;
          if (valid_d[N-1:EX_S] == '0) begin
            state_d = StHalted;
          end
        end else begin
          valid_d[ID_S] = valid_q[IF_S];
          valid_d[IF_S] = if_valid;
          pc_en         = 1'b1;
          if (id_halt && valid_q[ID_S]) begin
            state_d = StDrain;
          end
        end
      end
    end

    // Keep enables quiet while reset is held, independent of input activity.
    if (rst) begin
      stage_en = '0;
      pc_en    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StRun;
      valid_q <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      load_q  <= '0;
      wdog_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      load_q  <= load_d;
      wdog_q  <= wdog_d;
      err_q   <= err_d;
    end
  end

  assign stage_valid = valid_q;
  assign halted      = (state_q == StHalted);
  assign err         = err_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench: two controllers (with and without forwarding) against an instruction-slot model.
module tb_pipe_ctrl;

  localparam int N    = 5;
  localparam int AW   = 3;
  localparam int SMAX = 4;
  localparam int MRun = 0, MDrain = 1, MHalt = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          if_valid = 1'b0;
  logic [AW-1:0] id_rs_addr = '0, id_rt_addr = '0, id_rd_addr = '0;
  logic          id_rs_used = 1'b0, id_rt_used = 1'b0, id_reg_write = 1'b0;
  logic          id_is_load = 1'b0, id_halt = 1'b0, ex_redirect = 1'b0, mem_stall = 1'b0;

  logic [N-1:0] stage_en [2];
  logic [N-1:0] stage_valid [2];
  logic         pc_en [2], bubble_ex [2], flush_front [2], halted [2], err [2];

  always #5 clk = ~clk;

  pipe_ctrl #(.NUM_STAGES(N), .REG_AW(AW), .FORWARD(1), .STALL_MAX(SMAX)) u_dut_fw (
    .clk(clk), .rst(rst), .if_valid(if_valid),
    .id_rs_addr(id_rs_addr), .id_rs_used(id_rs_used),
    .id_rt_addr(id_rt_addr), .id_rt_used(id_rt_used),
    .id_rd_addr(id_rd_addr), .id_reg_write(id_reg_write), .id_is_load(id_is_load),
    .id_halt(id_halt), .ex_redirect(ex_redirect), .mem_stall(mem_stall),
    .stage_en(stage_en[0]), .stage_valid(stage_valid[0]), .pc_en(pc_en[0]),
    .bubble_ex(bubble_ex[0]), .flush_front(flush_front[0]), .halted(halted[0]), .err(err[0])
  );

  pipe_ctrl #(.NUM_STAGES(N), .REG_AW(AW), .FORWARD(0), .STALL_MAX(SMAX)) u_dut_nf (
    .clk(clk), .rst(rst), .if_valid(if_valid),
    .id_rs_addr(id_rs_addr), .id_rs_used(id_rs_used),
    .id_rt_addr(id_rt_addr), .id_rt_used(id_rt_used),
    .id_rd_addr(id_rd_addr), .id_reg_write(id_reg_write), .id_is_load(id_is_load),
    .id_halt(id_halt), .ex_redirect(ex_redirect), .mem_stall(mem_stall),
    .stage_en(stage_en[1]), .stage_valid(stage_valid[1]), .pc_en(pc_en[1]),
    .bubble_ex(bubble_ex[1]), .flush_front(flush_front[1]), .halted(halted[1]), .err(err[1])
  );

  // Model: one instruction slot per stage; index 0 = forwarding DUT, 1 = no-forwarding DUT.
  typedef struct { bit v; bit [AW-1:0] rd; bit wr; bit ld; } slot_t;
  slot_t pipe [2][N];
  int    mode [2];
  bit    merr [2];
  int    stalls [2];
  int    bub_cnt [2];
  bit    last_flush [2];
  int    n_pass = 0, n_fail = 0, n_total = 0;

  task automatic chk(string tag, int m, logic [N-1:0] got, logic [N-1:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s dut%0d got=%b exp=%b", tag, m, got, exp);
    end
  endtask

  // A source is unavailable if an older writer's result can't reach ID yet:
  // with forwarding only a load sitting in EX, without it any writer before WB.
  function automatic bit pending(int m, logic [AW-1:0] src);
    for (int s = 2; s <= N - 2; s++)
      if (pipe[m][s].v && pipe[m][s].wr && pipe[m][s].rd == src && (m == 1 || (s == 2 && pipe[m][s].ld)))
        return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit model_hazard(int m);
    return mode[m] == MRun && pipe[m][1].v &&
           ((id_rs_used && pending(m, id_rs_addr)) || (id_rt_used && pending(m, id_rt_addr)));
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      for (int s = 0; s < N; s++) begin
        pipe[m][s].v = 0; pipe[m][s].rd = 0; pipe[m][s].wr = 0; pipe[m][s].ld = 0;
      end
      mode[m] = MRun; merr[m] = 0; stalls[m] = 0;
    end
  endtask

  task automatic model_advance(int m, bit st, bit haz, bit redir);
    slot_t nxt [N];
    bit any;
    if (st) begin
      stalls[m]++;
      if (stalls[m] >= SMAX) merr[m] = 1;
      return;
    end
    stalls[m] = 0;
    if (ex_redirect && (mode[m] == MHalt || !pipe[m][2].v)) merr[m] = 1;
    if (mode[m] == MHalt) return;
    for (int s = N - 1; s >= 3; s--) nxt[s] = pipe[m][s-1];
    nxt[2].v = pipe[m][1].v; nxt[2].rd = id_rd_addr; nxt[2].wr = id_reg_write; nxt[2].ld = id_is_load;
    nxt[1] = pipe[m][1];
    nxt[0] = pipe[m][0];
    if (redir) begin
      for (int s = 0; s < 3; s++) nxt[s].v = 0;
      mode[m] = MRun;
    end else if (haz) begin
      nxt[2].v = 0;
    end else if (mode[m] == MDrain) begin
      any = 0;
      for (int s = 0; s < 3; s++) nxt[s].v = 0;
      for (int s = 0; s < N; s++) any |= nxt[s].v;
      if (!any) mode[m] = MHalt;
    end else begin
      nxt[1] = pipe[m][0];
      nxt[0].v = if_valid;
      if (id_halt && pipe[m][1].v) mode[m] = MDrain;
    end
    for (int s = 0; s < N; s++) pipe[m][s] = nxt[s];
  endtask

  task automatic step();
    bit haz, redir, st, epc, ebub, efl;
    bit [N-1:0] ev, een;
    @(negedge clk);
    for (int m = 0; m < 2; m++) begin
      st    = mem_stall;
      haz   = model_hazard(m);
      redir = ex_redirect && pipe[m][2].v && mode[m] != MHalt;
      for (int s = 0; s < N; s++) ev[s] = pipe[m][s].v;
      een = '0; epc = 0; ebub = 0; efl = 0;
      if (!st && mode[m] != MHalt) begin
        if (redir) begin een = '1; epc = 1; efl = 1; end
        else if (haz) begin een = 5'b11100; ebub = 1; end
        else if (mode[m] == MDrain) een = 5'b11100;
        else begin een = '1; epc = 1; end
      end
      chk("stage_valid", m, stage_valid[m], ev);
      chk("stage_en", m, stage_en[m], een);
      chk("pc_en", m, pc_en[m], epc);
      chk("bubble_ex", m, bubble_ex[m], ebub);
      chk("flush_front", m, flush_front[m], efl);
      chk("halted", m, halted[m], mode[m] == MHalt);
      chk("err", m, err[m], merr[m]);
      bub_cnt[m] += int'(bubble_ex[m]);
      last_flush[m] = flush_front[m];
      model_advance(m, st, haz, redir);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    if_valid = 0; id_rs_addr = 0; id_rs_used = 0; id_rt_addr = 0; id_rt_used = 0;
    id_rd_addr = 0; id_reg_write = 0; id_is_load = 0; id_halt = 0; ex_redirect = 0; mem_stall = 0;
  endtask

  task automatic do_reset(bit stall_during);
    rst = 1; mem_stall = stall_during;
    #2;
    for (int m = 0; m < 2; m++) begin
      chk("rst_stage_en", m, stage_en[m], '0);
      chk("rst_stage_valid", m, stage_valid[m], '0);
      chk("rst_pc_en", m, pc_en[m], '0);
      chk("rst_bubble", m, bubble_ex[m], '0);
      chk("rst_flush", m, flush_front[m], '0);
      chk("rst_halted", m, halted[m], '0);
      chk("rst_err", m, err[m], '0);
    end
    model_reset();
    @(posedge clk);
    #1;
    rst = 0; idle();
  endtask

  // Independent ALU ops: read r6/r7, write r0..r4, so nothing ever depends.
  task automatic fill(int cycles);
    logic [N-1:0] fill_exp [5];
    fill_exp[0] = 5'd1; fill_exp[1] = 5'd3; fill_exp[2] = 5'd7; fill_exp[3] = 5'd15; fill_exp[4] = 5'd31;
    for (int k = 0; k < cycles; k++) begin
      if_valid = 1; id_rs_addr = 7; id_rs_used = 1; id_rt_addr = 6; id_rt_used = 1;
      id_rd_addr = AW'(k); id_reg_write = 1; id_is_load = 0;
      step();
      for (int m = 0; m < 2; m++) chk("fill", m, stage_valid[m], fill_exp[k]);
    end
  endtask

  initial begin
    int k;
    int stall_run;
    idle();
    do_reset(0);

    // Back-to-back independent ops fill the pipe.
    fill(5);

    // LD r1 then ADD r2,r1,r3, the ADD held in ID until it issues.
    id_rs_addr = 7; id_rs_used = 1; id_rt_used = 0; id_rd_addr = 1; id_reg_write = 1; id_is_load = 1;
    step();
    bub_cnt[0] = 0; bub_cnt[1] = 0;
    id_rs_addr = 1; id_rt_addr = 3; id_rt_used = 1; id_rd_addr = 2; id_is_load = 0;
    repeat (3) step();
    chk("loaduse_bubbles", 0, N'(bub_cnt[0]), N'(1));
    chk("loaduse_bubbles", 1, N'(bub_cnt[1]), N'(2));

    // Three-cycle memory stall mid-stream stays below the watchdog limit.
    idle(); if_valid = 1; mem_stall = 1;
    repeat (3) step();
    mem_stall = 0;
    step();
    for (int m = 0; m < 2; m++) chk("stall3_err", m, err[m], '0);

    // Redirect from EX with three instructions in flight; HALT in ID is dropped.
    do_reset(0);
    idle(); if_valid = 1;
    repeat (3) step();
    for (int m = 0; m < 2; m++) chk("pre_redirect", m, stage_valid[m], 5'b00111);
    if_valid = 0; ex_redirect = 1; id_halt = 1;
    step();
    ex_redirect = 0; id_halt = 0;
    for (int m = 0; m < 2; m++) begin
      chk("redirect_flush", m, last_flush[m], 1'b1);
      chk("post_redirect", m, stage_valid[m], 5'b01000);
    end
    if_valid = 1;
    repeat (3) step();
    for (int m = 0; m < 2; m++) chk("redirect_run", m, pc_en[m], 1'b1);

    // Random traffic: dependent loads/ALU ops, short stalls, legal redirects.
    stall_run = 0;
    for (int i = 0; i < 300; i++) begin
      if_valid     = ($urandom_range(0, 3) != 0);
      id_rs_addr   = AW'($urandom_range(0, 7));
      id_rt_addr   = AW'($urandom_range(0, 7));
      id_rd_addr   = AW'($urandom_range(0, 7));
      id_rs_used   = ($urandom_range(0, 1) == 1);
      id_rt_used   = ($urandom_range(0, 1) == 1);
      id_reg_write = ($urandom_range(0, 3) != 0);
      id_is_load   = ($urandom_range(0, 2) == 0);
      id_halt      = 0;
      mem_stall    = (stall_run < SMAX - 1) && ($urandom_range(0, 9) == 0);
      stall_run    = mem_stall ? stall_run + 1 : 0;
      ex_redirect  = pipe[0][2].v && pipe[1][2].v && ($urandom_range(0, 7) == 0);
      step();
    end

    // Stall of exactly STALL_MAX cycles trips the sticky error.
    idle(); mem_stall = 1;
    repeat (SMAX) step();
    mem_stall = 0;
    step();
    for (int m = 0; m < 2; m++) chk("stall_max_err", m, err[m], 1'b1);

    // HALT reaches ID behind three older instructions, then drains.
    do_reset(0);
    fill(5);
    idle(); id_halt = 1;
    step();
    id_halt = 0;
    k = 0;
    while (halted[0] !== 1'b1 && k < 10) begin
      step();
      k++;
    end
    chk("drain_len", 0, N'(k), N'(3));
    for (int m = 0; m < 2; m++) begin
      chk("halted_empty", m, stage_valid[m], '0);
      chk("halted_flag", m, halted[m], 1'b1);
    end
    ex_redirect = 1;
    step();
    ex_redirect = 0;
    step();
    for (int m = 0; m < 2; m++) chk("redirect_halted_err", m, err[m], 1'b1);

    // Reset asserted during a stalled drain.
    do_reset(0);
    fill(5);
    idle(); id_halt = 1;
    step();
    id_halt = 0;
    step();
    mem_stall = 1;
    step();
    do_reset(1);
    if_valid = 1;
    step();
    for (int m = 0; m < 2; m++) begin
      chk("after_rst_pc_en", m, pc_en[m], 1'b1);
      chk("after_rst_halted", m, halted[m], '0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule
